// File: rtl/iob_rr_arbiter.sv
// iob_rr_arbiter
//   Shares one native-bus slave port between N_MASTERS native-bus masters
//   using round-robin arbitration with at most one transaction in flight.
//   After a master is served, the search for the next winner starts at
//   the master just after it.
//
// Optional feature (macro IOB_RR_ARBITER_TIMEOUT_EN):
//   A watchdog counts BUSY cycles without s_ready. When it expires, the
//   arbiter completes the transaction itself with m_rdata=0 and pulses
//   timeout_err together with m_ready. Without the macro there is no
//   counter, no timeout_err port, and the arbiter waits for s_ready
//   indefinitely.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-low reset
//   m_valid      per-master request valid, held until that master's m_ready
//   m_addr       per-master address (master 0 in the LSBs)
//   m_wdata      per-master write data
//   m_wstrb      per-master byte strobes (all zero = read)
//   m_rdata      registered read data, broadcast to all masters
//   m_ready      registered one-hot completion pulse to the served master
//   s_valid      slave request valid (high exactly in BUSY)
//   s_addr       slave address, muxed from master[grant]
//   s_wdata      slave write data, muxed from master[grant]
//   s_wstrb      slave strobes, muxed from master[grant]
//   s_rdata      slave read data
//   s_ready      slave completion
//   grant        index of the current or last granted master
//   busy         high while a transaction is in flight
//   timeout_err  (optional) watchdog completion flag, aligned with m_ready

module iob_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT_W = 8,
  localparam int GRANT_W  = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1,
  localparam int STRB_W   = DATA_W / 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_MASTERS-1:0]          m_valid,
  input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
  input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
  input  logic [N_MASTERS*STRB_W-1:0]   m_wstrb,
  output logic [DATA_W-1:0]             m_rdata,
  output logic [N_MASTERS-1:0]          m_ready,
  output logic                          s_valid,
  output logic [ADDR_W-1:0]             s_addr,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [STRB_W-1:0]             s_wstrb,
  input  logic [DATA_W-1:0]             s_rdata,
  input  logic                          s_ready,
  output logic [GRANT_W-1:0]            grant,
  output logic                          busy
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
  ,
  output logic                          timeout_err
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [GRANT_W-1:0]   grant_q, grant_d;
  logic [GRANT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [N_MASTERS-1:0] m_ready_q, m_ready_d;
  logic [DATA_W-1:0]    m_rdata_q, m_rdata_d;
  logic [GRANT_W-1:0]   pick;
  logic [GRANT_W-1:0]   next_ptr;
  logic                 any_valid;
  logic                 done;

`ifdef IOB_RR_ARBITER_TIMEOUT_EN
  // Expiry is detected one count early so that completion happens on the
  // same edge where the counter would reach its all-ones value.
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

  logic [TIMEOUT_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 tmo_hit;

  assign tmo_hit = (tmo_cnt_q == TMO_LAST);
`endif

  // Round-robin search: first requesting master at or after rr_ptr,
  // wrapping modulo N_MASTERS (works for non-power-of-two counts).
  always_comb begin
    int idx;
    idx       = 0;
    pick      = rr_ptr_q;
    any_valid = 1'b0;
    for (int i = 0; i < N_MASTERS; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!any_valid && m_valid[idx]) begin
        any_valid = 1'b1;
        pick      = GRANT_W'(idx);
      end
    end
  end

  // Pointer value for after the current grant completes.
  always_comb begin
    if (int'(grant_q) >= N_MASTERS - 1) next_ptr = '0;
    else                                next_ptr = grant_q + 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    m_ready_d = '0;
    m_rdata_d = m_rdata_q;
    done      = 1'b0;
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
    tmo_cnt_d     = tmo_cnt_q;
    timeout_err_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
        tmo_cnt_d = '0;
`endif
        if (any_valid) begin
          grant_d = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A real s_ready takes priority over a coincident watchdog expiry.
        if (s_ready) begin
          done      = 1'b1;
          m_rdata_d = s_rdata;
        end
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
        else if (tmo_hit) begin
          done          = 1'b1;
          m_rdata_d     = '0;
          timeout_err_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
`endif
        if (done) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
          for (int i = 0; i < N_MASTERS; i++) begin
            m_ready_d[i] = (int'(grant_q) == i);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset abandons any in-flight transaction: s_valid follows state_q and
  // drops as soon as rst is asserted, and no m_ready is produced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      m_ready_q <= '0;
      m_rdata_q <= '0;
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      m_ready_q <= m_ready_d;
      m_rdata_q <= m_rdata_d;
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
      tmo_cnt_q     <= tmo_cnt_d;
      timeout_err_q <= timeout_err_d;
`endif
    end
  end

  assign s_valid = (state_q == BUSY);
  assign busy    = (state_q == BUSY);
  assign grant   = grant_q;
  assign m_ready = m_ready_q;
  assign m_rdata = m_rdata_q;
  assign s_addr  = m_addr[grant_q*ADDR_W +: ADDR_W];
  assign s_wdata = m_wdata[grant_q*DATA_W +: DATA_W];
  assign s_wstrb = m_wstrb[grant_q*STRB_W +: STRB_W];
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
  assign timeout_err = timeout_err_q;
`endif

endmodule

// File: tb/tb_iob_rr_arbiter.sv
// tb_iob_rr_arbiter
//   Self-checking bench for iob_rr_arbiter with two masters. Master and
//   slave agents drive the DUT. A transaction-level reference model
//   predicts which master is served, when it completes, and with what data.
//   Outputs are sampled 1 ns after each rising clock edge. Inputs are
//   driven at the same point.
//   When IOB_RR_ARBITER_TIMEOUT_EN is defined, the watchdog is also
//   exercised with TIMEOUT_W=4.

module tb_iob_rr_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int GW = 1;
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 8;
`endif

  logic            clk;
  logic            rst;
  logic [N-1:0]    m_valid;
  logic [N*AW-1:0] m_addr;
  logic [N*DW-1:0] m_wdata;
  logic [N*SW-1:0] m_wstrb;
  logic [DW-1:0]   m_rdata;
  logic [N-1:0]    m_ready;
  logic            s_valid;
  logic [AW-1:0]   s_addr;
  logic [DW-1:0]   s_wdata;
  logic [SW-1:0]   s_wstrb;
  logic [DW-1:0]   s_rdata;
  logic            s_ready;
  logic [GW-1:0]   grant;
  logic            busy;
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
  logic            timeout_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // master agent state
  logic [AW-1:0] req_addr  [N];
  logic [DW-1:0] req_wdata [N];
  logic [SW-1:0] req_wstrb [N];
  int            mst_left  [N];
  int            done_cnt  [N];
  int            req_prob;

  // slave agent state
  bit            slv_enable;
  bit            slv_rand;
  int            slv_lat;
  bit            slv_active;
  int            slv_wait;
  bit            slv_use_fixed;
  logic [DW-1:0] slv_fixed_data;

  // reference model state
  bit            mdl_busy;
  int            mdl_grant;
  int            mdl_ptr;
  int            mdl_cnt;
  logic [N-1:0]  mdl_ready;
  logic [DW-1:0] mdl_rdata;
  bit            mdl_terr;

  iob_rr_arbiter #(
    .N_MASTERS (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .TIMEOUT_W (TW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_valid     (m_valid),
    .m_addr      (m_addr),
    .m_wdata     (m_wdata),
    .m_wstrb     (m_wstrb),
    .m_rdata     (m_rdata),
    .m_ready     (m_ready),
    .s_valid     (s_valid),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_rdata     (s_rdata),
    .s_ready     (s_ready),
    .grant       (grant),
    .busy        (busy)
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack the per-master request fields into the flat DUT buses.
  always_comb begin
    m_addr  = '0;
    m_wdata = '0;
    m_wstrb = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW]  = req_addr[i];
      m_wdata[i*DW +: DW] = req_wdata[i];
      m_wstrb[i*SW +: SW] = req_wstrb[i];
    end
  end

  // Abort the run if a bounded wait somehow never returns.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Winner rule: the first requester found walking upward from ptr,
  // modulo the number of masters.
  function automatic int pick_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    mdl_busy  = 0;
    mdl_grant = 0;
    mdl_ptr   = 0;
    mdl_cnt   = 0;
    mdl_ready = '0;
    mdl_rdata = '0;
    mdl_terr  = 0;
  endtask

  // Advance the model by one clock, using the inputs the DUT is about
  // to sample.
  task automatic model_step();
    mdl_ready = '0;
    mdl_terr  = 0;
    if (mdl_busy) begin
      if (s_ready) begin
        mdl_ready[mdl_grant] = 1'b1;
        mdl_rdata = s_rdata;
        mdl_ptr   = (mdl_grant + 1) % N;
        mdl_busy  = 0;
      end
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
      else begin
        mdl_cnt++;
        if (mdl_cnt == (1 << TW) - 1) begin
          mdl_ready[mdl_grant] = 1'b1;
          mdl_rdata = '0;
          mdl_terr  = 1;
          mdl_ptr   = (mdl_grant + 1) % N;
          mdl_busy  = 0;
        end
      end
`endif
    end else if (m_valid != '0) begin
      mdl_grant = pick_winner(m_valid, mdl_ptr);
      mdl_busy  = 1;
      mdl_cnt   = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_request(input int i, input logic [AW-1:0] a,
                             input logic [DW-1:0] d, input logic [SW-1:0] s);
    req_addr[i]  = a;
    req_wdata[i] = d;
    req_wstrb[i] = s;
    m_valid[i]   = 1'b1;
  endtask

  // Slave answers after a latency counted from the first cycle it sees
  // s_valid. Masters drop valid on m_ready and may issue their next
  // request in the same cycle.
  task automatic drive_agents();
    logic [SW-1:0] st;
    if (s_ready) begin
      s_ready    = 1'b0;
      slv_active = 0;
    end else if (!s_valid) begin
      slv_active = 0;
    end else if (slv_enable) begin
      if (!slv_active) begin
        slv_active = 1;
        slv_wait   = slv_rand ? int'($urandom_range(0, 3)) : slv_lat;
      end
      if (slv_wait == 0) begin
        s_ready = 1'b1;
        s_rdata = slv_use_fixed ? slv_fixed_data : DW'($urandom);
      end else begin
        slv_wait--;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (m_ready[i]) begin
        m_valid[i] = 1'b0;
        done_cnt[i]++;
      end
      if (!m_valid[i] && mst_left[i] > 0 && int'($urandom_range(0, 99)) < req_prob) begin
        st = ($urandom_range(0, 1) == 0) ? '0 : SW'($urandom);
        new_request(i, AW'($urandom), DW'($urandom), st);
        mst_left[i]--;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    slv_active = 0;
    s_ready    = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    tick();
  endtask

  // Reset state of every observable output.
  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    tests_run++;
    if (s_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_s_valid: got %b want 0", s_valid); end
    tests_run++;
    if (m_ready !== '0) begin tests_failed++; $display("[TB] FAIL reset_m_ready: got %b want 00", m_ready); end
    tests_run++;
    if (grant !== '0) begin tests_failed++; $display("[TB] FAIL reset_grant: got %0d want 0", grant); end
    tests_run++;
    if (m_rdata !== '0) begin tests_failed++; $display("[TB] FAIL reset_m_rdata: got %h want 0", m_rdata); end
    #3;
    rst = 1'b1;
    tick();
  endtask

  // Master 0 reads 0x100, slave answers two cycles after s_valid rises.
  task automatic test_single();
    int cyc;
    slv_enable = 1; slv_rand = 0; slv_lat = 2;
    slv_use_fixed = 1; slv_fixed_data = 32'hCAFEF00D;
    new_request(0, 32'h100, 32'h0, 4'h0);
    tick();
    tests_run++;
    if (s_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_s_valid: got %b want 1", s_valid); end
    tests_run++;
    if (s_addr !== 32'h100) begin tests_failed++; $display("[TB] FAIL single_s_addr: got %h want 00000100", s_addr); end
    tests_run++;
    if (s_wstrb !== 4'h0) begin tests_failed++; $display("[TB] FAIL single_s_wstrb: got %h want 0", s_wstrb); end
    cyc = 1;
    while (cyc < 20) begin
      drive_agents();
      tick();
      cyc++;
      if (m_ready != '0) break;
    end
    tests_run++;
    if (cyc !== 4) begin tests_failed++; $display("[TB] FAIL single_latency: m_ready at cycle %0d want 4", cyc); end
    tests_run++;
    if (m_ready !== 2'b01) begin tests_failed++; $display("[TB] FAIL single_m_ready: got %b want 01", m_ready); end
    tests_run++;
    if (m_rdata !== 32'hCAFEF00D) begin tests_failed++; $display("[TB] FAIL single_m_rdata: got %h want cafef00d", m_rdata); end
    tests_run++;
    if (s_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_s_valid_drop: got %b want 0", s_valid); end
    slv_use_fixed = 0;
    drive_agents();
    tick();
  endtask

  // Both masters request at once right after reset; master 1 writes.
  task automatic test_simultaneous();
    logic [N-1:0] ord [2];
    int n;
    bit seen1;
    do_reset();
    slv_enable = 1; slv_rand = 0; slv_lat = 1;
    new_request(0, AW'($urandom), DW'($urandom), 4'h0);
    new_request(1, AW'($urandom), 32'h12345678, 4'hF);
    n = 0; seen1 = 0;
    ord[0] = '0; ord[1] = '0;
    for (int c = 0; c < 30 && n < 2; c++) begin
      tick();
      if (busy && grant == 1'b1 && !seen1) begin
        seen1 = 1;
        tests_run++;
        if (s_wdata !== 32'h12345678) begin tests_failed++; $display("[TB] FAIL simul_s_wdata: got %h want 12345678", s_wdata); end
        tests_run++;
        if (s_wstrb !== 4'hF) begin tests_failed++; $display("[TB] FAIL simul_s_wstrb: got %h want f", s_wstrb); end
      end
      if (m_ready != '0) begin
        ord[n] = m_ready;
        n++;
        tests_run++;
        if (m_rdata !== mdl_rdata) begin tests_failed++; $display("[TB] FAIL simul_m_rdata: got %h want %h", m_rdata, mdl_rdata); end
      end
      drive_agents();
    end
    tests_run++;
    if (n !== 2 || !seen1) begin tests_failed++; $display("[TB] FAIL simul_count: got %0d completions want 2", n); end
    tests_run++;
    if (ord[0] !== 2'b01) begin tests_failed++; $display("[TB] FAIL simul_first: got %b want 01", ord[0]); end
    tests_run++;
    if (ord[1] !== 2'b10) begin tests_failed++; $display("[TB] FAIL simul_second: got %b want 10", ord[1]); end
    tick();
  endtask

  // Both masters keep requesting for eight transactions in total.
  task automatic test_fairness();
    int ord [8];
    int n, c0, c1, repeats;
    slv_enable = 1; slv_rand = 1;
    mst_left[0] = 4; mst_left[1] = 4; req_prob = 100;
    n = 0;
    for (int c = 0; c < 200 && n < 8; c++) begin
      drive_agents();
      tick();
      if (m_ready != '0) begin
        tests_run++;
        if (m_ready !== mdl_ready) begin tests_failed++; $display("[TB] FAIL fair_m_ready: got %b want %b", m_ready, mdl_ready); end
        ord[n] = (m_ready == 2'b01) ? 0 : 1;
        n++;
      end
    end
    c0 = 0; c1 = 0; repeats = 0;
    for (int k = 0; k < n; k++) begin
      if (ord[k] == 0) c0++; else c1++;
      if (k > 0 && ord[k] == ord[k-1]) repeats++;
    end
    tests_run++;
    if (n !== 8) begin tests_failed++; $display("[TB] FAIL fair_count: got %0d want 8", n); end
    tests_run++;
    if (repeats !== 0) begin tests_failed++; $display("[TB] FAIL fair_alternate: got %0d repeats want 0", repeats); end
    tests_run++;
    if (c0 !== 4 || c1 !== 4) begin tests_failed++; $display("[TB] FAIL fair_split: got %0d/%0d want 4/4", c0, c1); end
    drive_agents();
    tick();
  endtask

  // Master 1 alone issues three reads; slave answers immediately.
  task automatic test_back_to_back();
    logic [5:0] pat;
    int r0, r1;
    slv_enable = 1; slv_rand = 0; slv_lat = 0;
    mst_left[0] = 0; mst_left[1] = 3; req_prob = 100;
    pat = '0; r0 = 0; r1 = 0;
    for (int c = 0; c < 6; c++) begin
      drive_agents();
      tick();
      pat[c] = s_valid;
      if (m_ready[0]) r0++;
      if (m_ready[1]) r1++;
    end
    tests_run++;
    if (pat !== 6'b010101) begin tests_failed++; $display("[TB] FAIL b2b_pattern: got %b want 010101", pat); end
    tests_run++;
    if (r1 !== 3) begin tests_failed++; $display("[TB] FAIL b2b_m1_ready: got %0d want 3", r1); end
    tests_run++;
    if (r0 !== 0) begin tests_failed++; $display("[TB] FAIL b2b_m0_ready: got %0d want 0", r0); end
    drive_agents();
    tick();
  endtask

  // Reset while master 1 waits on a silent slave.
  task automatic test_reset_mid();
    int cyc;
    slv_enable = 0;
    new_request(1, AW'($urandom), DW'($urandom), 4'h0);
    tick();
    tick();
    tests_run++;
    if (busy !== 1'b1 || grant !== 1'b1) begin tests_failed++; $display("[TB] FAIL mid_pre_busy: got busy=%b grant=%0d want 1/1", busy, grant); end
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (s_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_s_valid: got %b want 0", s_valid); end
    tests_run++;
    if (m_ready !== '0) begin tests_failed++; $display("[TB] FAIL mid_m_ready: got %b want 00", m_ready); end
    tests_run++;
    if (grant !== '0) begin tests_failed++; $display("[TB] FAIL mid_grant: got %0d want 0", grant); end
    model_reset();
    slv_active = 0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    slv_enable = 1; slv_rand = 0; slv_lat = 1;
    cyc = 0;
    while (cyc < 20) begin
      drive_agents();
      tick();
      cyc++;
      if (m_ready != '0) break;
    end
    tests_run++;
    if (m_ready !== 2'b10) begin tests_failed++; $display("[TB] FAIL mid_complete: got %b want 10", m_ready); end
    tests_run++;
    if (m_rdata !== mdl_rdata) begin tests_failed++; $display("[TB] FAIL mid_m_rdata: got %h want %h", m_rdata, mdl_rdata); end
    drive_agents();
    tick();
  endtask

  // Random traffic from both masters, checked cycle by cycle against the model.
  task automatic test_random();
    int c;
    slv_enable = 1; slv_rand = 1; req_prob = 30;
    mst_left[0] = int'($urandom_range(3, 8));
    mst_left[1] = int'($urandom_range(3, 8));
    c = 0;
    while (c < 600 && (mst_left[0] > 0 || mst_left[1] > 0 || m_valid != '0 || busy || s_ready)) begin
      drive_agents();
      tick();
      c++;
      tests_run++;
      if (busy !== mdl_busy || s_valid !== mdl_busy) begin tests_failed++; $display("[TB] FAIL rand_busy: got busy=%b s_valid=%b want %b", busy, s_valid, mdl_busy); end
      tests_run++;
      if (m_ready !== mdl_ready) begin tests_failed++; $display("[TB] FAIL rand_m_ready: got %b want %b", m_ready, mdl_ready); end
      tests_run++;
      if (grant !== GW'(mdl_grant)) begin tests_failed++; $display("[TB] FAIL rand_grant: got %0d want %0d", grant, mdl_grant); end
      tests_run++;
      if (m_rdata !== mdl_rdata) begin tests_failed++; $display("[TB] FAIL rand_m_rdata: got %h want %h", m_rdata, mdl_rdata); end
      if (mdl_busy) begin
        tests_run++;
        if (s_addr !== req_addr[mdl_grant] || s_wdata !== req_wdata[mdl_grant] || s_wstrb !== req_wstrb[mdl_grant]) begin
          tests_failed++;
          $display("[TB] FAIL rand_slave_req: got %h/%h/%h want %h/%h/%h", s_addr, s_wdata, s_wstrb,
                   req_addr[mdl_grant], req_wdata[mdl_grant], req_wstrb[mdl_grant]);
        end
      end
    end
    tests_run++;
    if (c >= 600) begin tests_failed++; $display("[TB] FAIL rand_drain: got %0d cycles want < 600", c); end
  endtask

`ifdef IOB_RR_ARBITER_TIMEOUT_EN
  // Silent slave: the watchdog completes after 15 BUSY cycles.
  task automatic test_timeout();
    int cyc;
    slv_enable = 0;
    new_request(0, AW'($urandom), DW'($urandom), 4'h0);
    cyc = 0;
    while (cyc < 40) begin
      tick();
      cyc++;
      if (m_ready != '0) break;
      drive_agents();
    end
    tests_run++;
    if (cyc !== 16) begin tests_failed++; $display("[TB] FAIL tmo_latency: m_ready at cycle %0d want 16", cyc); end
    tests_run++;
    if (m_ready !== 2'b01 || m_ready !== mdl_ready) begin tests_failed++; $display("[TB] FAIL tmo_m_ready: got %b want 01", m_ready); end
    tests_run++;
    if (timeout_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL tmo_err: got %b want 1", timeout_err); end
    tests_run++;
    if (m_rdata !== '0) begin tests_failed++; $display("[TB] FAIL tmo_m_rdata: got %h want 0", m_rdata); end
    tests_run++;
    if (s_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL tmo_s_valid: got %b want 0", s_valid); end
    drive_agents();
    tick();
    slv_enable = 1; slv_rand = 0; slv_lat = 1;
    new_request(1, AW'($urandom), DW'($urandom), 4'h0);
    cyc = 0;
    while (cyc < 20) begin
      tick();
      cyc++;
      if (m_ready != '0) break;
      drive_agents();
    end
    tests_run++;
    if (m_ready !== 2'b10) begin tests_failed++; $display("[TB] FAIL tmo_next_ready: got %b want 10", m_ready); end
    tests_run++;
    if (timeout_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL tmo_next_err: got %b want 0", timeout_err); end
    tests_run++;
    if (m_rdata !== mdl_rdata) begin tests_failed++; $display("[TB] FAIL tmo_next_rdata: got %h want %h", m_rdata, mdl_rdata); end
    drive_agents();
    tick();
  endtask
`endif

  initial begin
    rst     = 1'b0;
    m_valid = '0;
    s_ready = 1'b0;
    s_rdata = '0;
    slv_enable = 1; slv_rand = 0; slv_lat = 1; slv_active = 0; slv_wait = 0;
    slv_use_fixed = 0; slv_fixed_data = '0;
    req_prob = 100;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = '0; req_wdata[i] = '0; req_wstrb[i] = '0;
      mst_left[i] = 0; done_cnt[i] = 0;
    end
    model_reset();

    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef IOB_RR_ARBITER_TIMEOUT_EN
    test_timeout();
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
